// File: rtl/usr_pkg.sv
// usr_pkg -- shared definitions for the universal shift register.
//   MODE_HOLD/MODE_SHR/MODE_SHL/MODE_LOAD : 2-bit mode encodings
//   usr_state_t                           : burst engine states
//   usr_step()                            : single-step next value of the register
// The step function works on a USR_MAX_W-bit container so one function serves
// every register width; callers zero-extend q in and truncate the result.
package usr_pkg;

   localparam int unsigned USR_MAX_W = 64;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } usr_state_t;

   // Next value for hold/shift modes; load is handled by the caller since it
   // needs the parallel data. Bits of q at or above width must be zero.
   function automatic logic [USR_MAX_W-1:0] usr_step(
      input logic [USR_MAX_W-1:0] q,
      input int unsigned          width,
      input logic [1:0]           mode,
      input logic                 rot,
      input logic                 sin_l,
      input logic                 sin_r
   );
      logic [USR_MAX_W-1:0] mask;
      logic [USR_MAX_W-1:0] msb_sel;
      logic                 msb;
      logic                 in_bit;
      logic [USR_MAX_W-1:0] r;
      mask    = ~({USR_MAX_W{1'b1}} << width);
      msb_sel = {{(USR_MAX_W-1){1'b0}}, 1'b1} << (width - 1);
      msb     = |(q & msb_sel);
      r       = q;
      case (mode)
         MODE_SHR: begin
            in_bit = rot ? q[0] : sin_l;
            r = (q >> 1) | (in_bit ? msb_sel : '0);
         end
         MODE_SHL: begin
            in_bit = rot ? msb : sin_r;
            r = ((q << 1) & mask) | {{(USR_MAX_W-1){1'b0}}, in_bit};
         end
         default: r = q;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/universal_shift_reg.sv
// universal_shift_reg -- WIDTH-bit register with hold, shift right, shift left
// and parallel load, fill or rotate shifting, and an N-step burst engine.
//   clk, rst (sync, active-low)      : clock and reset
//   en                               : global enable; 0 freezes all state
//   mode[1:0], rot, sin_l, sin_r, d  : operation select, rotate, serial/parallel data
//   start, amt[AMT_W-1:0]            : burst request and step count
//   q, so_l, so_r                    : register contents and serial outputs
//   busy, done                       : burst in progress / one-cycle completion pulse
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter int unsigned         WIDTH     = 8,
   parameter logic [WIDTH-1:0]    RESET_VAL = '0,
   localparam int unsigned        AMT_W     = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             rot,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic [WIDTH-1:0] d,
   input  logic             start,
   input  logic [AMT_W-1:0] amt,
   output logic [WIDTH-1:0] q,
   output logic             so_l,
   output logic             so_r,
   output logic             busy,
   output logic             done
);

   usr_state_t       state;
   logic [AMT_W-1:0] cnt;
   logic [1:0]       burst_mode;
   logic             burst_rot;
   logic [1:0]       step_mode;
   logic             step_rot;
   logic             is_shift;
   logic [WIDTH-1:0] q_step;

   // Burst steps use the mode/rot latched at start; idle steps use live inputs.
   always_comb begin
      step_mode = mode;
      step_rot  = rot;
      if (state == ST_BURST) begin
         step_mode = burst_mode;
         step_rot  = burst_rot;
      end
      is_shift = (mode == MODE_SHR) || (mode == MODE_SHL);
      q_step   = WIDTH'(usr_step(USR_MAX_W'(q), WIDTH, step_mode, step_rot, sin_l, sin_r));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         q          <= RESET_VAL;
         state      <= ST_IDLE;
         cnt        <= '0;
         burst_mode <= MODE_HOLD;
         burst_rot  <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (en) begin
            case (state)
               ST_IDLE: begin
                  if (start && is_shift) begin
                     // The start edge itself never shifts.
                     if (amt == '0) begin
                        done <= 1'b1;
                     end else begin
                        burst_mode <= mode;
                        burst_rot  <= rot;
                        cnt        <= amt;
                        state      <= ST_BURST;
                     end
                  end else if (mode == MODE_LOAD) begin
                     q <= d;
                  end else begin
                     q <= q_step;
                  end
               end
               ST_BURST: begin
                  q   <= q_step;
                  cnt <= cnt - 1'b1;
                  if (cnt == AMT_W'(1)) begin
                     state <= ST_IDLE;
                     done  <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy = (state == ST_BURST);
   assign so_l = q[WIDTH-1];
   assign so_r = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg -- directed self-checking bench for universal_shift_reg
// at WIDTH=8, RESET_VAL=8'h00. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_universal_shift_reg;

   localparam int unsigned W  = 8;
   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [1:0]    mode;
   logic          rot;
   logic          sin_l;
   logic          sin_r;
   logic [W-1:0]  d;
   logic          start;
   logic [AW-1:0] amt;
   logic [W-1:0]  q;
   logic          so_l;
   logic          so_r;
   logic          busy;
   logic          done;

   int n_cmp = 0;
   int n_err = 0;

   universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot),
      .sin_l(sin_l), .sin_r(sin_r), .d(d), .start(start), .amt(amt),
      .q(q), .so_l(so_l), .so_r(so_r), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load(input logic [7:0] val);
      mode = 2'b11; d = val; start = 1'b0;
      step();
      mode = 2'b00;
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; mode = 2'b00; rot = 1'b0; sin_l = 1'b0; sin_r = 1'b0;
      d = '0; start = 1'b0; amt = '0;
      step();
      check("rst_q", q, 8'h00);
      check("rst_busy", 8'(busy), 8'h0);
      check("rst_done", 8'(done), 8'h0);
      check("rst_so_l", 8'(so_l), 8'h0);
      check("rst_so_r", 8'(so_r), 8'h0);

      // load and hold
      rst = 1'b1; en = 1'b1;
      load(8'hA5);
      check("load_a5", q, 8'hA5);
      mode = 2'b00;
      repeat (3) step();
      check("hold_mode00", q, 8'hA5);
      en = 1'b0; mode = 2'b01;
      repeat (3) step();
      check("hold_en0", q, 8'hA5);

      // single fill steps
      en = 1'b1; mode = 2'b01; rot = 1'b0; sin_l = 1'b1;
      step();
      check("shr_fill", q, 8'hD2);
      check("shr_so_l", 8'(so_l), 8'h1);
      check("shr_so_r", 8'(so_r), 8'h0);
      load(8'hA5);
      mode = 2'b10; sin_r = 1'b0;
      step();
      check("shl_fill", q, 8'h4A);
      sin_r = 1'b1;
      step();
      check("shl_fill1", q, 8'h95);
      check("shl_so_l", 8'(so_l), 8'h1);
      check("shl_so_r", 8'(so_r), 8'h1);
      mode = 2'b01; rot = 1'b1;
      step();
      check("shr_rot", q, 8'hCA);

      // burst rotate left by 3 from 81, with ignored inputs mid-burst
      load(8'h81);
      mode = 2'b10; rot = 1'b1; amt = 4'd3; start = 1'b1;
      step();
      check("b_start_q", q, 8'h81);
      check("b_start_busy", 8'(busy), 8'h1);
      mode = 2'b11; d = 8'hFF; rot = 1'b0; amt = 4'd7;
      step();
      check("b_s1", q, 8'h03);
      step();
      check("b_s2", q, 8'h06);
      check("b_s2_busy", 8'(busy), 8'h1);
      check("b_s2_done", 8'(done), 8'h0);
      step();
      check("b_end_q", q, 8'h0C);
      check("b_end_busy", 8'(busy), 8'h0);
      check("b_end_done", 8'(done), 8'h1);
      mode = 2'b00; start = 1'b0;
      step();
      check("b_after_done", 8'(done), 8'h0);
      check("b_after_q", q, 8'h0C);

      // same burst with a two-cycle stall after the first step
      load(8'h81);
      mode = 2'b10; rot = 1'b1; amt = 4'd3; start = 1'b1;
      step();
      start = 1'b0; mode = 2'b00;
      step();
      check("st_s1", q, 8'h03);
      en = 1'b0;
      step();
      check("st_hold1", q, 8'h03);
      check("st_hold1_busy", 8'(busy), 8'h1);
      step();
      check("st_hold2", q, 8'h03);
      check("st_hold2_done", 8'(done), 8'h0);
      en = 1'b1;
      step();
      check("st_s2", q, 8'h06);
      check("st_s2_done", 8'(done), 8'h0);
      step();
      check("st_end_q", q, 8'h0C);
      check("st_end_done", 8'(done), 8'h1);
      step();
      check("st_after_done", 8'(done), 8'h0);

      // amt = 0: done pulse, no shift, never busy
      mode = 2'b01; rot = 1'b0; sin_l = 1'b1; amt = 4'd0; start = 1'b1;
      step();
      check("a0_q", q, 8'h0C);
      check("a0_busy", 8'(busy), 8'h0);
      check("a0_done", 8'(done), 8'h1);
      start = 1'b0; mode = 2'b00;
      step();
      check("a0_done_off", 8'(done), 8'h0);
      check("a0_q2", q, 8'h0C);

      // start with load mode is ignored and the load applies
      mode = 2'b11; d = 8'h5A; amt = 4'd2; start = 1'b1;
      step();
      check("start_load_q", q, 8'h5A);
      check("start_load_busy", 8'(busy), 8'h0);
      start = 1'b0;

      // reset mid-burst aborts without done
      load(8'h0C);
      mode = 2'b10; rot = 1'b1; amt = 4'd3; start = 1'b1;
      step();
      start = 1'b0; mode = 2'b00;
      step();
      check("rb_s1", q, 8'h18);
      rst = 1'b0;
      step();
      check("rb_q", q, 8'h00);
      check("rb_busy", 8'(busy), 8'h0);
      check("rb_done", 8'(done), 8'h0);
      rst = 1'b1;
      step();
      check("rb_done_after", 8'(done), 8'h0);
      check("rb_busy_after", 8'(busy), 8'h0);

      // amt = 10 fill right with sin_l = 1 from 00
      mode = 2'b01; rot = 1'b0; sin_l = 1'b1; amt = 4'd10; start = 1'b1;
      step();
      start = 1'b0; mode = 2'b00;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 9) check("f10_busy9", 8'(busy), 8'h1);
      end
      check("f10_q", q, 8'hFF);
      check("f10_done", 8'(done), 8'h1);
      check("f10_busy", 8'(busy), 8'h0);

      // amt = 10 rotate left from 81 wraps modulo 8 -> rotate by 2
      load(8'h81);
      mode = 2'b10; rot = 1'b1; amt = 4'd10; start = 1'b1;
      step();
      start = 1'b0; mode = 2'b00;
      repeat (10) step();
      check("r10_q", q, 8'h06);
      check("r10_done", 8'(done), 8'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register: the successor to the single-bit D latch/flip-flop cells, generalised to a WIDTH-bit register with hold, shift-right, shift-left and parallel-load modes. It supports fill or rotate shifting and serial in/out on both ends. A burst engine performs an N-position shift from a single `start` strobe, with busy/done status. It sits in the flip-flop/latch library as the reusable storage-and-shift primitive for serialisers and pattern generators.

## Interface
- `WIDTH`, 8: register width in bits, at least 2.
- `RESET_VAL`, 0: value loaded into `q` on reset, WIDTH bits.
- `AMT_W`, derived as $clog2(WIDTH)+1: width of the `amt` port. Not user-overridable.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `en` in 1: operation enable. When 0, all state holds, including a burst in progress.
- `mode` in 2: 00 hold, 01 shift right (toward bit 0), 10 shift left (toward MSB), 11 parallel load.
- `rot` in 1: 1 selects rotate; 0 selects fill from the serial inputs.
- `sin_l` in 1: serial in on the MSB side, used by shift right.
- `sin_r` in 1: serial in on the LSB side, used by shift left.
- `d` in WIDTH: parallel load data.
- `start` in 1: burst request; honoured only in IDLE with `en`=1 and mode 01 or 10.
- `amt` in AMT_W: burst shift count, 0..2^AMT_W-1.
- `q` out WIDTH: register contents.
- `so_l` out 1: equals `q[WIDTH-1]`, combinational from `q`.
- `so_r` out 1: equals `q[0]`, combinational from `q`.
- `busy` out 1: high while in BURST.
- `done` out 1: one-cycle pulse at burst completion.

## Operation
- The FSM has two states, IDLE and BURST.
- Single step, right shift, fill: `q` becomes {sin_l, q[WIDTH-1:1]}.
- Single step, right shift, rotate: `q` becomes {q[0], q[WIDTH-1:1]}.
- Single step, left shift, fill: `q` becomes {q[WIDTH-2:0], sin_r}.
- Single step, left shift, rotate: `q` becomes {q[WIDTH-2:0], q[WIDTH-1]}.
- Load: `q` becomes `d`.
- IDLE, `en`=1, `start`=0: apply `mode` once per edge.
- IDLE, `en`=1, `start`=1, shift mode, `amt`>0:
  - no shift on this edge;
  - latch `mode` and `rot`; counter takes `amt`; go to BURST.
- IDLE, `start`=1, shift mode, `amt`=0: no shift, stay IDLE, `done`=1 for the next cycle.
- IDLE, `start`=1 with mode 00 or 11: `start` is ignored and the mode applies normally.
- BURST, `en`=1:
  - one step per edge using the latched mode/rot;
  - `sin_l`/`sin_r` are sampled live on each step;
  - counter decrements.
- BURST, `en`=1, step with counter=1: return to IDLE and assert `done` for the following cycle.
- BURST, `en`=0: `q`, counter and state hold.
- BURST: `start`, `mode`, `rot`, `d` are ignored.
- `amt`≥WIDTH is legal and is stepped literally. Fill mode ends all serial-in; rotate mode wraps modulo WIDTH.

## Timing
- Reset values: `q`=RESET_VAL, `so_l`=RESET_VAL[WIDTH-1], `so_r`=RESET_VAL[0], `busy`=0, `done`=0, state IDLE, counter 0.
- Reset has priority over everything, including mid-burst. It aborts the burst with no `done` pulse.
- Single-step latency: `q` updates on the same edge that samples `en`/`mode`.
- Burst latency with no stalls: start edge E, steps on edges E+1..E+amt.
  - `busy`=1 from after E until after E+amt.
  - `done`=1 during the cycle after E+amt.
- Each `en`=0 cycle during a burst delays completion by one cycle.
- `done` is never high for two consecutive cycles.

## Structure
- Package `usr_pkg` holds:
  - the mode constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD;
  - the state enum (ST_IDLE, ST_BURST);
  - a pure function `usr_step(q, mode, rot, sin_l, sin_r)` returning the single-step next value.
- No sub-module. Single-step and burst paths share `usr_step`.

## Test plan
All scenarios use WIDTH=8, RESET_VAL=8'h00.
- Reset: `rst`=0 for one edge from any state → `q`=00, `busy`=0, `done`=0, `so_l`=`so_r`=0.
- Load and hold: load `d`=A5 → `q`=A5. Then mode 00, or `en`=0 with any mode, for 3 edges → `q` stays A5.
- Fill steps from A5:
  - shift right with `sin_l`=1 → D2;
  - shift left with `sin_r`=0, from A5 → 4A;
  - `so_r`/`so_l` track `q[0]`/`q[7]`.
- Burst rotate left, `amt`=3, from 81:
  - `busy` high for 3 cycles, then `q`=0C;
  - `done` pulses once;
  - `start` and mode changes during the burst have no effect.
- Stall: same burst with `en`=0 for 2 cycles after the first step → `q` holds 03 during the stall; `done` arrives 2 cycles late; final `q`=0C.
- Edge cases:
  - `amt`=0 → `done` pulse with `q` unchanged and `busy` never high;
  - `rst`=0 mid-burst → `q`=00, `busy`=0, no `done`;
  - `amt`=10 fill right with `sin_l`=1 → FF.
